// File: rtl/jtpopeye_dma_if.sv
// jtpopeye_dma_if: bus bundle between the sprite DMA engine and the rest of the system.
// master: DMA side (busrq_n, dma_cs, AD_DMA, obj_addr/obj_data/obj_we, dma_done, dma_timeout).
// slave: system side (VB, busak_n, DD_DMA from main RAM).
interface jtpopeye_dma_if;
  logic       VB;           // vertical blank, rising edge starts a transfer
  logic       busrq_n;      // Z80 bus request, active low
  logic       busak_n;      // Z80 bus acknowledge, active low
  logic       dma_cs;       // main RAM serves DMA reads while high
  logic [9:0] AD_DMA;       // main RAM read address
  logic [7:0] DD_DMA;       // main RAM read data, valid 2 clk after AD_DMA
  logic [9:0] obj_addr;     // object buffer write address
  logic [7:0] obj_data;     // object buffer write data
  logic       obj_we;       // object buffer write strobe
  logic       dma_done;     // one-clk pulse at transfer completion
  logic       dma_timeout;  // one-clk pulse when the grant never came

  modport master (
    input  VB, busak_n, DD_DMA,
    output busrq_n, dma_cs, AD_DMA, obj_addr, obj_data, obj_we, dma_done, dma_timeout
  );

  modport slave (
    output VB, busak_n, DD_DMA,
    input  busrq_n, dma_cs, AD_DMA, obj_addr, obj_data, obj_we, dma_done, dma_timeout
  );
endinterface

// File: rtl/jtpopeye_dma.sv
// jtpopeye_dma: on each VB rising edge borrows the Z80 bus and copies LEN bytes of main RAM
// into the object buffer. Latency: busrq_n falls 1 clk after the VB edge is seen; each byte is
// written 2 clk after its address is issued; XFER lasts LEN+2 clk, then dma_done pulses.
// Backpressure: none inside a transfer; busak_n rising mid-transfer aborts without dma_done.
// Ports: clk, rst_n (asynchronous, active low), bus (jtpopeye_dma_if.master).
// Option: define JTPOPEYE_DMA_TIMEOUT_EN to give up on a grant after TIMEOUT clk
// (dma_timeout pulses); otherwise the request waits forever and dma_timeout is tied to 0.
module jtpopeye_dma #(
  parameter int LEN     = 1024,  // bytes per transfer, 1..1024
  parameter int TIMEOUT = 255    // grant wait limit in clk, only with JTPOPEYE_DMA_TIMEOUT_EN
) (
  input  logic           clk,
  input  logic           rst_n,
  jtpopeye_dma_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_DONE
  } state_t;

  // Counters are 11 bits so that LEN=1024 (and LEN+1 cycle index) never wraps.
  localparam logic [10:0] LAST_ISSUE = 11'(LEN - 1);
  localparam logic [10:0] LAST_CYCLE = 11'(LEN + 1);

  // Legal range marker: an out-of-range configuration shows up as this scope.
  if ((LEN < 1) || (LEN > 1024) || (TIMEOUT < 1)) begin : g_param_out_of_range
  end

  state_t      state;
  logic        vb_q;       // VB registered on the previous clk
  logic        edge_en;    // low for the first clk after reset so a VB already high is not an edge
  logic [10:0] rd_addr;    // issued read address
  logic [10:0] xfer_cnt;   // clk index inside XFER, 0..LEN+1
  logic [9:0]  wr_addr;
  logic        busrq_r;
  logic        cs_r;
  logic        we_r;
  logic        done_r;
  logic        vb_rise;

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt;
  logic        to_r;
`endif

  assign vb_rise = bus.VB & ~vb_q & edge_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      vb_q     <= 1'b0;
      edge_en  <= 1'b0;
      rd_addr  <= '0;
      xfer_cnt <= '0;
      wr_addr  <= '0;
      busrq_r  <= 1'b1;
      cs_r     <= 1'b0;
      we_r     <= 1'b0;
      done_r   <= 1'b0;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
      to_cnt   <= '0;
      to_r     <= 1'b0;
`endif
    end else begin
      vb_q    <= bus.VB;
      edge_en <= 1'b1;
      done_r  <= 1'b0;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
      to_r    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (vb_rise) begin
            state   <= S_REQ;
            busrq_r <= 1'b0;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
            to_cnt  <= '0;
`endif
          end
        end

        S_REQ: begin
          if (!bus.busak_n) begin
            state    <= S_XFER;
            rd_addr  <= '0;
            xfer_cnt <= '0;
            cs_r     <= 1'b1;
          end
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state   <= S_IDLE;
            busrq_r <= 1'b1;
            to_r    <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end

        S_XFER: begin
          if (bus.busak_n) begin
            // Bus taken back by the CPU: drop everything, no completion pulse.
            state   <= S_IDLE;
            busrq_r <= 1'b1;
            cs_r    <= 1'b0;
            we_r    <= 1'b0;
          end else if (xfer_cnt == LAST_CYCLE) begin
            state   <= S_DONE;
            busrq_r <= 1'b1;
            cs_r    <= 1'b0;
            we_r    <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            xfer_cnt <= xfer_cnt + 11'd1;
            if (rd_addr < LAST_ISSUE) begin
              rd_addr <= rd_addr + 11'd1;
            end
            // Cycle k writes the byte issued at cycle k-2; the write for the next
            // cycle (xfer_cnt+1) therefore targets address xfer_cnt-1.
            if (xfer_cnt != 11'd0) begin
              we_r    <= 1'b1;
              wr_addr <= 10'(xfer_cnt - 11'd1);
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state   <= S_IDLE;
          busrq_r <= 1'b1;
          cs_r    <= 1'b0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busrq_n  = busrq_r;
  assign bus.dma_cs   = cs_r;
  assign bus.AD_DMA   = rd_addr[9:0];
  assign bus.obj_addr = wr_addr;
  // RAM data arrives exactly in the write cycle, so it passes straight through.
  assign bus.obj_data = we_r ? bus.DD_DMA : 8'h00;
  assign bus.obj_we   = we_r;
  assign bus.dma_done = done_r;

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
  assign bus.dma_timeout = to_r;
`else
  assign bus.dma_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_jtpopeye_dma.sv
`timescale 1ns/1ps
module tb_jtpopeye_dma;
  localparam int LEN_A = 1024;
  localparam int LEN_B = 4;
  localparam int TO    = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jtpopeye_dma_if bus_a ();
  jtpopeye_dma_if bus_b ();

  jtpopeye_dma #(.LEN(LEN_A), .TIMEOUT(TO)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus_a.master));
  jtpopeye_dma #(.LEN(LEN_B), .TIMEOUT(TO)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.master));

  // Stimulus drivers
  logic vb_a = 1'b0, vb_b = 1'b0, ak_a = 1'b1, ak_b = 1'b1;
  logic sel = 1'b0;  // 0: observe/drive the LEN_A instance, 1: the LEN_B instance
  assign bus_a.VB = vb_a;
  assign bus_b.VB = vb_b;
  assign bus_a.busak_n = ak_a;
  assign bus_b.busak_n = ak_b;

  // Main RAM model: shared contents, two-clk read latency per instance
  logic [7:0] ram [1024];
  logic [7:0] pa1, pa2, pb1, pb2;
  always @(posedge clk) begin
    pa1 <= ram[bus_a.AD_DMA];
    pa2 <= pa1;
    pb1 <= ram[bus_b.AD_DMA];
    pb2 <= pb1;
  end
  assign bus_a.DD_DMA = pa2;
  assign bus_b.DD_DMA = pb2;

  // Observed instance
  wire       m_we   = sel ? bus_b.obj_we      : bus_a.obj_we;
  wire [9:0] m_addr = sel ? bus_b.obj_addr    : bus_a.obj_addr;
  wire [7:0] m_data = sel ? bus_b.obj_data    : bus_a.obj_data;
  wire       m_done = sel ? bus_b.dma_done    : bus_a.dma_done;
  wire       m_to   = sel ? bus_b.dma_timeout : bus_a.dma_timeout;
  wire       m_cs   = sel ? bus_b.dma_cs      : bus_a.dma_cs;
  wire       m_rq   = sel ? bus_b.busrq_n     : bus_a.busrq_n;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs every write and pulse with the cycle it was seen in
  logic [9:0] wq_addr[$];
  logic [7:0] wq_data[$];
  int         wq_cyc[$];
  int done_n = 0, done_cyc = 0, to_n = 0, to_cyc = 0, cs_cyc = 0, rq_cyc = 0;
  logic cs_q = 1'b0, rq_q = 1'b1;
  always @(negedge clk) begin
    if (m_we === 1'b1) begin
      wq_addr.push_back(m_addr);
      wq_data.push_back(m_data);
      wq_cyc.push_back(cyc);
    end
    if (m_done === 1'b1) begin done_n++; done_cyc = cyc; end
    if (m_to === 1'b1)   begin to_n++;   to_cyc = cyc;   end
    if (m_cs === 1'b1 && cs_q !== 1'b1) cs_cyc = cyc;
    if (m_rq === 1'b0 && rq_q === 1'b1) rq_cyc = cyc;
    cs_q = m_cs;
    rq_q = m_rq;
  end

  int n_chk = 0, n_pass = 0;
  int vb_set_cyc = 0;

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_vb(input logic v);
    if (sel) vb_b = v; else vb_a = v;
  endtask

  task automatic set_ak(input logic v);
    if (sel) ak_b = v; else ak_a = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_req(input int limit, output bit expired);
    expired = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (m_rq === 1'b0) begin expired = 1'b0; break; end
    end
  endtask

  task automatic wait_done(input int base, input int limit, output bit expired);
    expired = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (done_n > base) begin expired = 1'b0; break; end
    end
  endtask

  // One VB frame: edge, grant after dly clk, wait for completion, release the bus
  task automatic run_frame(input int dly, output bit req_to, output bit done_to);
    int bd;
    bd = done_n;
    set_vb(1'b1);
    vb_set_cyc = cyc;
    wait_req(20, req_to);
    tick(dly);
    set_ak(1'b0);
    set_vb(1'b0);
    wait_done(bd, LEN_A + 50, done_to);
    tick(1);
    set_ak(1'b1);
    tick(2);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    vb_a  = 1'b1;  // VB already high across reset release
    #2 rst_n = 1'b0;
    #10;
    n_chk++; if (bus_a.busrq_n !== 1'b1) $display("FAIL reset_busrq_n: got %b want 1", bus_a.busrq_n); else n_pass++;
    n_chk++; if (bus_a.dma_cs !== 1'b0) $display("FAIL reset_dma_cs: got %b want 0", bus_a.dma_cs); else n_pass++;
    n_chk++; if (bus_a.AD_DMA !== 10'd0) $display("FAIL reset_AD_DMA: got %0h want 0", bus_a.AD_DMA); else n_pass++;
    n_chk++; if (bus_a.obj_addr !== 10'd0) $display("FAIL reset_obj_addr: got %0h want 0", bus_a.obj_addr); else n_pass++;
    n_chk++; if (bus_a.obj_data !== 8'd0) $display("FAIL reset_obj_data: got %0h want 0", bus_a.obj_data); else n_pass++;
    n_chk++; if (bus_a.obj_we !== 1'b0) $display("FAIL reset_obj_we: got %b want 0", bus_a.obj_we); else n_pass++;
    n_chk++; if (bus_a.dma_done !== 1'b0) $display("FAIL reset_dma_done: got %b want 0", bus_a.dma_done); else n_pass++;
    n_chk++; if (bus_a.dma_timeout !== 1'b0) $display("FAIL reset_dma_timeout: got %b want 0", bus_a.dma_timeout); else n_pass++;
    n_chk++; if (bus_b.busrq_n !== 1'b1) $display("FAIL reset_busrq_n_len4: got %b want 1", bus_b.busrq_n); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    tick(10);
    n_chk++; if (bus_a.busrq_n !== 1'b1) $display("FAIL reset_vb_high_no_start: busrq_n got %b want 1", bus_a.busrq_n); else n_pass++;
    vb_a = 1'b0;
    tick(3);
  endtask

  task automatic test_nominal();
    int bw, bd, bad, c0;
    bit rx, dx;
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    bw = wq_addr.size();
    bd = done_n;
    run_frame(5, rx, dx);
    c0 = cs_cyc;
    n_chk++; if (rx) $display("FAIL nominal_req: got no request want busrq_n low"); else n_pass++;
    n_chk++; if (rq_cyc != vb_set_cyc + 1) $display("FAIL nominal_req_latency: got cycle %0d want %0d", rq_cyc, vb_set_cyc + 1); else n_pass++;
    n_chk++; if (dx) $display("FAIL nominal_done_wait: got no dma_done want one"); else n_pass++;
    n_chk++; if (wq_addr.size() - bw != LEN_A) $display("FAIL nominal_write_count: got %0d want %0d", wq_addr.size() - bw, LEN_A); else n_pass++;
    bad = 0;
    for (int k = 0; k < LEN_A; k++) begin
      if (bw + k >= wq_addr.size()) bad++;
      else if (wq_addr[bw+k] !== 10'(k) || wq_data[bw+k] !== 8'(k) || wq_cyc[bw+k] != c0 + 2 + k) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL nominal_writes: got %0d bad writes want 0", bad); else n_pass++;
    n_chk++; if (done_n - bd != 1) $display("FAIL nominal_done_count: got %0d want 1", done_n - bd); else n_pass++;
    n_chk++; if (done_cyc != c0 + LEN_A + 2) $display("FAIL nominal_done_cycle: got %0d want %0d", done_cyc, c0 + LEN_A + 2); else n_pass++;
    n_chk++; if (bus_a.busrq_n !== 1'b1) $display("FAIL nominal_busrq_after: got %b want 1", bus_a.busrq_n); else n_pass++;
    n_chk++; if (bus_a.dma_cs !== 1'b0) $display("FAIL nominal_cs_after: got %b want 0", bus_a.dma_cs); else n_pass++;
  endtask

  task automatic test_vb_ignored();
    int bw, bd, bad, rq0;
    bit rx, wx, dx;
    fill_random();
    bw = wq_addr.size();
    bd = done_n;
    set_vb(1'b1);
    wait_req(20, rx);
    tick(5);
    set_ak(1'b0);
    set_vb(1'b0);
    wx = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (wq_addr.size() >= bw + 50) begin wx = 1'b0; break; end
    end
    rq0 = rq_cyc;
    set_vb(1'b1);  // second edge in the middle of XFER
    tick(2);
    set_vb(1'b0);
    wait_done(bd, LEN_A + 50, dx);
    tick(1);
    set_ak(1'b1);
    tick(30);
    n_chk++; if (rx || wx || dx) $display("FAIL vbign_progress: got req/write/done stall %b%b%b want 000", rx, wx, dx); else n_pass++;
    n_chk++; if (done_n - bd != 1) $display("FAIL vbign_done_count: got %0d want 1", done_n - bd); else n_pass++;
    n_chk++; if (rq_cyc != rq0) $display("FAIL vbign_no_new_request: got request at %0d want none after %0d", rq_cyc, rq0); else n_pass++;
    n_chk++; if (bus_a.busrq_n !== 1'b1) $display("FAIL vbign_busrq_after: got %b want 1", bus_a.busrq_n); else n_pass++;
    n_chk++; if (wq_addr.size() - bw != LEN_A) $display("FAIL vbign_write_count: got %0d want %0d", wq_addr.size() - bw, LEN_A); else n_pass++;
    bad = 0;
    for (int k = 0; k < LEN_A; k++) begin
      if (bw + k >= wq_addr.size()) bad++;
      else if (wq_addr[bw+k] !== 10'(k) || wq_data[bw+k] !== ram[k]) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL vbign_writes: got %0d bad writes want 0", bad); else n_pass++;
  endtask

  task automatic test_abort();
    int bw, bd, bad;
    bit rx, dx, hit;
    fill_random();
    bw = wq_addr.size();
    bd = done_n;
    set_vb(1'b1);
    wait_req(20, rx);
    tick(5);
    set_ak(1'b0);
    set_vb(1'b0);
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_we === 1'b1 && m_addr === 10'd100) begin hit = 1'b1; break; end
    end
    set_ak(1'b1);  // CPU takes the bus back during write 100
    tick(20);
    n_chk++; if (!hit) $display("FAIL abort_reach_write100: got no write 100 want one"); else n_pass++;
    n_chk++; if (wq_addr.size() - bw != 101) $display("FAIL abort_write_count: got %0d want 101", wq_addr.size() - bw); else n_pass++;
    n_chk++; if (wq_addr.size() == 0 || wq_addr[wq_addr.size()-1] !== 10'd100) $display("FAIL abort_last_addr: got %0d want 100", (wq_addr.size() == 0) ? -1 : int'(wq_addr[wq_addr.size()-1])); else n_pass++;
    n_chk++; if (done_n != bd) $display("FAIL abort_no_done: got %0d pulses want 0", done_n - bd); else n_pass++;
    n_chk++; if (bus_a.busrq_n !== 1'b1 || bus_a.dma_cs !== 1'b0) $display("FAIL abort_bus_release: got busrq_n=%b dma_cs=%b want 1/0", bus_a.busrq_n, bus_a.dma_cs); else n_pass++;
    // next frame must run a complete transfer
    fill_random();
    bw = wq_addr.size();
    bd = done_n;
    run_frame($urandom_range(1, 9), rx, dx);
    n_chk++; if (rx || dx) $display("FAIL abort_rerun_stall: got req/done stall %b%b want 00", rx, dx); else n_pass++;
    n_chk++; if (wq_addr.size() - bw != LEN_A) $display("FAIL abort_rerun_count: got %0d want %0d", wq_addr.size() - bw, LEN_A); else n_pass++;
    bad = 0;
    for (int k = 0; k < LEN_A; k++) begin
      if (bw + k >= wq_addr.size()) bad++;
      else if (wq_addr[bw+k] !== 10'(k) || wq_data[bw+k] !== ram[k] || wq_cyc[bw+k] != cs_cyc + 2 + k) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL abort_rerun_writes: got %0d bad writes want 0", bad); else n_pass++;
    n_chk++; if (done_n - bd != 1) $display("FAIL abort_rerun_done: got %0d want 1", done_n - bd); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bw, bd, bad;
    bit rx, dx, hit;
    fill_random();
    set_vb(1'b1);
    wait_req(20, rx);
    tick(5);
    set_ak(1'b0);
    set_vb(1'b0);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (m_we === 1'b1 && m_addr === 10'd200) begin hit = 1'b1; break; end
    end
    rst_n = 1'b0;
    #1;
    n_chk++; if (!hit) $display("FAIL rstmid_reach_write200: got no write 200 want one"); else n_pass++;
    n_chk++; if (bus_a.busrq_n !== 1'b1) $display("FAIL rstmid_busrq_async: got %b want 1", bus_a.busrq_n); else n_pass++;
    n_chk++; if (bus_a.dma_cs !== 1'b0) $display("FAIL rstmid_cs_async: got %b want 0", bus_a.dma_cs); else n_pass++;
    n_chk++; if (bus_a.obj_we !== 1'b0) $display("FAIL rstmid_we_async: got %b want 0", bus_a.obj_we); else n_pass++;
    set_ak(1'b1);
    set_vb(1'b1);  // VB high across release must not start a transfer
    @(negedge clk) rst_n = 1'b1;
    bw = wq_addr.size();
    bd = done_n;
    tick(40);
    n_chk++; if (wq_addr.size() != bw) $display("FAIL rstmid_no_writes: got %0d writes want 0", wq_addr.size() - bw); else n_pass++;
    n_chk++; if (done_n != bd) $display("FAIL rstmid_no_done: got %0d pulses want 0", done_n - bd); else n_pass++;
    n_chk++; if (bus_a.busrq_n !== 1'b1) $display("FAIL rstmid_idle_busrq: got %b want 1", bus_a.busrq_n); else n_pass++;
    set_vb(1'b0);
    tick(2);
    fill_random();
    bw = wq_addr.size();
    bd = done_n;
    run_frame(5, rx, dx);
    n_chk++; if (rx || dx) $display("FAIL rstmid_rerun_stall: got req/done stall %b%b want 00", rx, dx); else n_pass++;
    bad = 0;
    for (int k = 0; k < LEN_A; k++) begin
      if (bw + k >= wq_addr.size()) bad++;
      else if (wq_addr[bw+k] !== 10'(k) || wq_data[bw+k] !== ram[k]) bad++;
    end
    n_chk++; if (bad != 0 || wq_addr.size() - bw != LEN_A) $display("FAIL rstmid_rerun_writes: got %0d bad of %0d want 0 of %0d", bad, wq_addr.size() - bw, LEN_A); else n_pass++;
    n_chk++; if (done_n - bd != 1) $display("FAIL rstmid_rerun_done: got %0d want 1", done_n - bd); else n_pass++;
  endtask

  task automatic test_timeout();
    int bw, bt;
    bit rx;
    bw = wq_addr.size();
    bt = to_n;
    set_vb(1'b1);
    wait_req(20, rx);
    set_vb(1'b0);
    n_chk++; if (rx) $display("FAIL timeout_req: got no request want busrq_n low"); else n_pass++;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    for (int i = 0; i < 50; i++) begin
      if (to_n > bt) break;
      tick(1);
    end
    tick(3);
    n_chk++; if (to_n - bt != 1) $display("FAIL timeout_pulse_count: got %0d want 1", to_n - bt); else n_pass++;
    n_chk++; if (to_cyc != rq_cyc + TO) $display("FAIL timeout_pulse_cycle: got %0d want %0d", to_cyc, rq_cyc + TO); else n_pass++;
    n_chk++; if (bus_a.busrq_n !== 1'b1) $display("FAIL timeout_busrq_after: got %b want 1", bus_a.busrq_n); else n_pass++;
    n_chk++; if (wq_addr.size() != bw) $display("FAIL timeout_no_writes: got %0d want 0", wq_addr.size() - bw); else n_pass++;
`else
    begin
      int bd;
      bit dx;
      bd = done_n;
      tick(300);
      n_chk++; if (bus_a.busrq_n !== 1'b0) $display("FAIL nogrant_still_waiting: busrq_n got %b want 0", bus_a.busrq_n); else n_pass++;
      n_chk++; if (to_n != bt) $display("FAIL nogrant_no_timeout: got %0d pulses want 0", to_n - bt); else n_pass++;
      n_chk++; if (wq_addr.size() != bw) $display("FAIL nogrant_no_writes: got %0d want 0", wq_addr.size() - bw); else n_pass++;
      set_ak(1'b0);
      wait_done(bd, LEN_A + 50, dx);
      tick(1);
      set_ak(1'b1);
      tick(2);
      n_chk++; if (dx || wq_addr.size() - bw != LEN_A) $display("FAIL nogrant_late_grant: got %0d writes want %0d", wq_addr.size() - bw, LEN_A); else n_pass++;
    end
`endif
  endtask

  task automatic test_len4();
    int bw, bd, bad;
    bit rx, dx;
    sel = 1'b1;
    tick(2);
    fill_random();
    bw = wq_addr.size();
    bd = done_n;
    run_frame($urandom_range(1, 6), rx, dx);
    n_chk++; if (rx || dx) $display("FAIL len4_stall: got req/done stall %b%b want 00", rx, dx); else n_pass++;
    n_chk++; if (wq_addr.size() - bw != LEN_B) $display("FAIL len4_write_count: got %0d want %0d", wq_addr.size() - bw, LEN_B); else n_pass++;
    bad = 0;
    for (int k = 0; k < LEN_B; k++) begin
      if (bw + k >= wq_addr.size()) bad++;
      else if (wq_addr[bw+k] !== 10'(k) || wq_data[bw+k] !== ram[k] || wq_cyc[bw+k] != cs_cyc + 2 + k) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL len4_writes: got %0d bad writes want 0", bad); else n_pass++;
    n_chk++; if (done_cyc != cs_cyc + 6) $display("FAIL len4_done_cycle: got %0d want %0d", done_cyc, cs_cyc + 6); else n_pass++;
    n_chk++; if (done_n - bd != 1) $display("FAIL len4_done_count: got %0d want 1", done_n - bd); else n_pass++;
    sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    test_reset();
    test_nominal();
    test_vb_ignored();
    test_abort();
    test_reset_mid();
    test_timeout();
    test_len4();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/jtpopeye_dma.md
JTPOPEYE_DMA -- requirements
Module: jtpopeye_dma

Interface
REQ-001 SHALL provide parameter LEN, default 1024, meaning bytes copied per transfer (1..1024).
REQ-002 SHALL provide parameter TIMEOUT, default 255, meaning clk cycles to wait for bus grant (used only under REQ-031).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port VB, input, 1, vertical blank; its rising edge triggers a transfer.
REQ-006 SHALL have port busrq_n, output, 1, Z80 bus request, active low.
REQ-007 SHALL have port busak_n, input, 1, Z80 bus acknowledge, active low.
REQ-008 SHALL have port dma_cs, output, 1, high while main RAM must serve DMA reads.
REQ-009 SHALL have port AD_DMA, output, 10, main RAM read address (upper-2K bank offset).
REQ-010 SHALL have port DD_DMA, input, 8, main RAM read data, valid 2 clk after AD_DMA.
REQ-011 SHALL have port obj_addr, output, 10, object buffer write address.
REQ-012 SHALL have port obj_data, output, 8, object buffer write data.
REQ-013 SHALL have port obj_we, output, 1, object buffer write strobe, one clk per byte.
REQ-014 SHALL have port dma_done, output, 1, one-clk pulse when a transfer completes.
REQ-015 SHALL have port dma_timeout, output, 1, one-clk pulse on grant timeout.

Function
REQ-016 SHALL implement states IDLE, REQ, XFER, DONE.
REQ-017 SHALL detect VB rising edge as VB high with VB registered low on the previous clk.
REQ-018 IDLE: on VB rising edge, go to REQ and drive busrq_n low on the next clk edge.
REQ-019 REQ: hold busrq_n low; when busak_n is sampled low, go to XFER with AD_DMA=0 and dma_cs=1.
REQ-020 XFER: AD_DMA SHALL increment by 1 every clk, from 0 to LEN-1, then hold.
REQ-021 Writeback SHALL run 2 clk behind issue: obj_we=1, obj_addr=issued address, obj_data=DD_DMA.
REQ-022 Exactly LEN obj_we pulses with ascending obj_addr 0..LEN-1 SHALL occur per transfer; XFER lasts LEN+2 clk.
REQ-023 After the last write, go to DONE: busrq_n=1, dma_cs=0, dma_done=1 for one clk, then IDLE.
REQ-024 VB rising edges outside IDLE SHALL be ignored, not queued.
REQ-025 busak_n going high during XFER SHALL abort: busrq_n=1, dma_cs=0, obj_we=0 next clk, IDLE, no dma_done.
REQ-026 Address counters SHALL be 11 bits internally so LEN=1024 terminates without 10-bit wrap-around.
REQ-027 obj_we SHALL be 0 in every state except the XFER writeback window.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, busrq_n=1, dma_cs=0, AD_DMA=0, obj_addr=0, obj_data=0, obj_we=0, dma_done=0, dma_timeout=0, VB edge register=0.
REQ-029 Reset asserted mid-transfer SHALL release the bus immediately; no partial completion pulse follows reset release.
REQ-030 After reset release, a transfer SHALL start only on a fresh VB rising edge; VB already high does not trigger it.

Configuration
REQ-031 With JTPOPEYE_DMA_TIMEOUT_EN defined, REQ SHALL count clk cycles; if busak_n stays high for TIMEOUT cycles: busrq_n=1, dma_timeout pulses one clk, IDLE.
REQ-032 Without JTPOPEYE_DMA_TIMEOUT_EN, REQ SHALL wait for a grant indefinitely, and dma_timeout SHALL be tied to 0.

Verification
REQ-033 Nominal transfer: RAM model with byte i = i[7:0], VB pulse, grant after 5 clk -> 1024 obj_we pulses, obj_data==obj_addr[7:0], one dma_done, busrq_n high afterwards.
REQ-034 Second VB edge inside XFER -> no restart; exactly one dma_done for that frame.
REQ-035 busak_n raised at write 100 -> no obj_we after the abort clk, dma_done never pulses, next VB edge runs a full transfer.
REQ-036 rst_n pulsed low during XFER -> busrq_n=1 and dma_cs=0 asynchronously; no activity until the next VB edge.
REQ-037 With JTPOPEYE_DMA_TIMEOUT_EN and TIMEOUT=8, busak_n held high -> dma_timeout pulses 8 clk after REQ entry, busrq_n=1, no obj_we.
REQ-038 LEN=4 -> exactly 4 writes to addresses 0..3; DONE reached 6 clk after XFER entry.
